mcp3008_spi: RTL and testbench

- SPI Mode 0 master that reads one 10-bit conversion from an MCP3008 8-channel ADC.
- A start pulse triggers one 17-SCK transaction: start/SGL/channel bits go out on MOSI, and 10 result bits are sampled from MISO.
- The block sits between system logic on the 50 MHz domain and the external ADC pins.
- It presents the result with a one-cycle data_valid strobe.

---
 rtl/mcp3008_spi_pkg.sv | 31 +++
 rtl/mcp3008_spi_if.sv | 12 +
 rtl/mcp3008_spi_sck_tick.sv | 50 +++++
 rtl/mcp3008_spi.sv | 150 +++++++++++++++
 tb/tb_mcp3008_spi.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mcp3008_spi_pkg.sv
// mcp3008_pkg: shared state encoding, frame constants and command builder for mcp3008_spi.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcp3008_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        TRANSFER = 2'd2,
        CS_HOLD  = 2'd3
    } state_t;

    localparam int NUM_SCK         = 17;
    localparam int CMD_BITS        = 5;
    localparam int DATA_BITS       = 10;
    localparam int FIRST_DATA_RISE = 8;

    localparam int RISE_W = $clog2(NUM_SCK + 1);
    typedef logic [RISE_W-1:0] rise_cnt_t;

    // Rise counter value after the final SCK rise of a frame.
    localparam rise_cnt_t LAST_RISE  = rise_cnt_t'(NUM_SCK);
    // Rise counter value (rises already done) at which MISO starts carrying B9.
    localparam rise_cnt_t SHIFT_FROM = rise_cnt_t'(FIRST_DATA_RISE - 1);

    // Command word in transmit order: start bit, SGL/DIFF, D2, D1, D0.
    function automatic logic [CMD_BITS-1:0] build_cmd(input logic sgl, input logic [2:0] ch);
        return {1'b1, sgl, ch};
    endfunction

endpackage

// File: rtl/mcp3008_spi_if.sv
// mcp3008_spi_if: the four SPI pins between the master and the MCP3008.
// Latency: n/a (wires only).
// Backpressure: n/a.
interface mcp3008_spi_if;
    logic MISO;
    logic MOSI;
    logic SCK;
    logic CS;

    modport master (input MISO, output MOSI, output SCK, output CS);
    modport slave  (output MISO, input MOSI, input SCK, input CS);
endinterface

// File: rtl/mcp3008_spi_sck_tick.sv
// spi_sck_tick: CLK_DIV half-period timer generating the registered SCK and its edge enables.
// Latency: first half_tick CLK_DIV clk after en rises; rise/fall enables coincide with the SCK update edge.
// Backpressure: none; run=0 suppresses further rises, en=0 parks the timer and SCK low.
module spi_sck_tick #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic run,
    output logic half_tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sck
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign half_tick = en && (cnt == LAST);
    assign rise_tick = half_tick && run && !sck;
    assign fall_tick = half_tick && sck;

    // Half-period counter; restarts at every tick and is held at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || half_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered SCK level, raised and lowered on the tick edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck <= 1'b0;
        end else if (!en) begin
            sck <= 1'b0;
        end else if (rise_tick) begin
            sck <= 1'b1;
        end else if (fall_tick) begin
            sck <= 1'b0;
        end
    end

endmodule

// File: rtl/mcp3008_spi.sv
// mcp3008_spi: SPI mode-0 master reading one 10-bit MCP3008 conversion per start pulse (MCP3008_DIFF_EN adds diff_mode).
// Latency: CS falls 1 clk after start is sampled; data_valid pulses 36*CLK_DIV clk after CS falls.
// Backpressure: none; start is only accepted in IDLE, anything else is dropped without queuing.
module mcp3008_spi
    import mcp3008_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           channel,
`ifdef MCP3008_DIFF_EN
    input  logic                 diff_mode,
`endif
    mcp3008_spi_if.master        spi,
    output logic [DATA_BITS-1:0] ADC_data,
    output logic                 data_valid
);

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  done;
    logic                  run_sck;
    logic                  tick_en;
    logic                  half_tick;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  sck;
    logic                  sgl_bit;
    logic [CMD_BITS-1:0]   cmd_word;
    logic [CMD_BITS-2:0]   cmd_sh;
    rise_cnt_t             rise_cnt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  cs_q;
    logic                  mosi_q;

`ifdef MCP3008_DIFF_EN
    assign sgl_bit = ~diff_mode;
`else
    assign sgl_bit = 1'b1;
`endif

    assign cmd_word = build_cmd(sgl_bit, channel);
    assign tick_en  = (state != IDLE);

    spi_sck_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (tick_en),
        .run       (run_sck),
        .half_tick (half_tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sck       (sck)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-phase controls; the first SCK rise is the tick that ends CS_SETUP,
    // and TRANSFER runs until the low phase after the last rise has elapsed.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        run_sck   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CS_SETUP;
                end
            end
            CS_SETUP: begin
                run_sck = 1'b1;
                if (half_tick) begin
                    state_nxt = TRANSFER;
                end
            end
            TRANSFER: begin
                run_sck = (rise_cnt != LAST_RISE);
                if (half_tick && !sck && (rise_cnt == LAST_RISE)) begin
                    state_nxt = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (half_tick) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: cmd_sh doubles as the channel/SGL latch, MOSI advances on falls,
    // MISO is captured on rises from B9 onward, result published with CS release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            cmd_sh     <= '0;
            rise_cnt   <= '0;
            shift_reg  <= '0;
            ADC_data   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (accept) begin
                cs_q      <= 1'b0;
                mosi_q    <= cmd_word[CMD_BITS-1];
                cmd_sh    <= cmd_word[CMD_BITS-2:0];
                rise_cnt  <= '0;
                shift_reg <= '0;
            end
            if (rise_tick) begin
                rise_cnt <= rise_cnt + rise_cnt_t'(1);
                if (rise_cnt >= SHIFT_FROM) begin
                    shift_reg <= {shift_reg[DATA_BITS-2:0], spi.MISO};
                end
            end
            if (fall_tick) begin
                mosi_q <= cmd_sh[CMD_BITS-2];
                cmd_sh <= {cmd_sh[CMD_BITS-3:0], 1'b0};
            end
            if (done) begin
                cs_q       <= 1'b1;
                ADC_data   <= shift_reg;
                data_valid <= 1'b1;
            end
        end
    end

    assign spi.CS   = cs_q;
    assign spi.MOSI = mosi_q;
    assign spi.SCK  = sck;

endmodule

// File: tb/tb_mcp3008_spi.sv
// tb_mcp3008_spi: directed bench for mcp3008_spi with a mode-0 MCP3008 slave model on the SPI pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_mcp3008_spi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] channel = 3'b000;
`ifdef MCP3008_DIFF_EN
    logic       diff_mode = 1'b0;
`endif
    logic [9:0] ADC_data;
    logic       data_valid;

    mcp3008_spi_if spi_bus();

    mcp3008_spi #(
        .CLK_DIV (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .channel    (channel),
`ifdef MCP3008_DIFF_EN
        .diff_mode  (diff_mode),
`endif
        .spi        (spi_bus),
        .ADC_data   (ADC_data),
        .data_valid (data_valid)
    );

    always #10 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Monitor / slave-model state, written only by the monitor process.
    int          cyc = 0;
    int          rise_total = 0;
    int          dv_total = 0;
    int          tr_rise = 0;
    int          tr_fall = 0;
    int          cs_fall_cyc = 0;
    int          dv_cyc = 0;
    int          rise_cyc [1:17];
    int          fall_cyc [1:17];
    logic [16:0] mosi_vec = '0;
    logic [9:0]  dv_data = '0;
    logic [15:0] slv_sh = 16'hD550;
    logic        sck_prev = 1'b0;
    logic        cs_prev = 1'b1;

    // MCP3008 model plus pin monitor, evaluated mid-cycle: shifts D550 out on SCK falls,
    // logs rise/fall cycles, MOSI at each rise and every data_valid cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cs_prev && !spi_bus.CS) begin
            cs_fall_cyc = cyc;
            tr_rise     = 0;
            tr_fall     = 0;
            mosi_vec    = '0;
        end
        if (spi_bus.CS !== 1'b0) begin
            slv_sh       = 16'hD550;
            spi_bus.MISO = 1'b0;
        end else if (sck_prev && !spi_bus.SCK) begin
            tr_fall = tr_fall + 1;
            if (tr_fall <= 17) fall_cyc[tr_fall] = cyc;
            spi_bus.MISO = slv_sh[15];
            slv_sh       = {slv_sh[14:0], 1'b0};
        end
        if (!sck_prev && spi_bus.SCK) begin
            rise_total = rise_total + 1;
            tr_rise    = tr_rise + 1;
            if (tr_rise <= 17) begin
                rise_cyc[tr_rise] = cyc;
                mosi_vec          = {mosi_vec[15:0], spi_bus.MOSI};
            end
        end
        if (data_valid) begin
            dv_total = dv_total + 1;
            dv_cyc   = cyc;
            dv_data  = ADC_data;
        end
        sck_prev = spi_bus.SCK;
        cs_prev  = spi_bus.CS;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One-cycle start request; CS must already be low one edge later.
    task automatic pulse_start(input logic [2:0] ch, input string tag);
        @(negedge clk);
        #1;
        channel = ch;
        start   = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk(tag, 32'(spi_bus.CS), 32'd0);
    endtask

    task automatic wait_dv(input int budget, input string tag);
        int base = dv_total;
        int n    = 0;
        while (dv_total == base && n < budget) begin
            step(1);
            n = n + 1;
        end
        chk(tag, 32'(dv_total != base), 32'd1);
    endtask

    int rise_base;
    int dv_base;
    int n_wait;
    int dv_first;
    logic [9:0] data_first;

    initial begin
        // Reset held low for 50 ns.
        #2 rst = 1'b0;
        #50;
        chk("rst_cs",   32'(spi_bus.CS),   32'd1);
        chk("rst_sck",  32'(spi_bus.SCK),  32'd0);
        chk("rst_mosi", 32'(spi_bus.MOSI), 32'd0);
        chk("rst_adc",  32'(ADC_data),     32'h0);
        chk("rst_dv",   32'(data_valid),   32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        step(30);
        chk("idle_sck", 32'(rise_total), 32'd0);
        chk("idle_cs",  32'(spi_bus.CS), 32'd1);
        chk("idle_dv",  32'(dv_total),   32'd0);

        // Basic read, channel 2.
        rise_base = rise_total;
        dv_base   = dv_total;
        pulse_start(3'b010, "rd_cs_lat");
        wait_dv(400, "rd_timeout");
        step(20);
        chk("rd_adc",     32'(ADC_data),            32'h150);
        chk("rd_dv_data", 32'(dv_data),             32'h150);
        chk("rd_dv_cnt",  32'(dv_total - dv_base),  32'd1);
        chk("rd_sck_cnt", 32'(rise_total - rise_base), 32'd17);
        chk("rd_mosi",    32'(mosi_vec),            32'({5'b11010, 12'b0}));
        chk("rd_dv_lat",  32'(dv_cyc - cs_fall_cyc), 32'd288);
        chk("rd_setup",   32'(rise_cyc[1] - cs_fall_cyc), 32'd8);
        chk("rd_hi1",     32'(fall_cyc[1] - rise_cyc[1]), 32'd8);
        chk("rd_lo1",     32'(rise_cyc[2] - fall_cyc[1]), 32'd8);
        chk("rd_hi17",    32'(fall_cyc[17] - rise_cyc[17]), 32'd8);
        chk("rd_cs_end",  32'(spi_bus.CS), 32'd1);

        // Channel 5 command, with a second start and channel change mid-transfer.
        rise_base = rise_total;
        dv_base   = dv_total;
        pulse_start(3'b101, "busy_cs_lat");
        step(100);
        pulse_start(3'b000, "busy_cs_still_low");
        wait_dv(400, "busy_timeout");
        step(320);
        chk("cmd_mosi",    32'(mosi_vec), 32'({5'b11101, 12'b0}));
        chk("busy_dv_cnt", 32'(dv_total - dv_base), 32'd1);
        chk("busy_sck",    32'(rise_total - rise_base), 32'd17);
        chk("busy_adc",    32'(ADC_data), 32'h150);

        // Reset after SCK rise 9 aborts without publishing.
        dv_base = dv_total;
        pulse_start(3'b010, "abort_cs_lat");
        n_wait = 0;
        while (tr_rise < 9 && n_wait < 400) begin
            step(1);
            n_wait = n_wait + 1;
        end
        chk("abort_reach9", 32'(tr_rise), 32'd9);
        rst = 1'b0;
        #1;
        chk("abort_cs",   32'(spi_bus.CS),   32'd1);
        chk("abort_sck",  32'(spi_bus.SCK),  32'd0);
        chk("abort_mosi", 32'(spi_bus.MOSI), 32'd0);
        chk("abort_adc0", 32'(ADC_data),     32'h0);
        step(3);
        rst = 1'b1;
        step(350);
        chk("abort_no_dv", 32'(dv_total - dv_base), 32'd0);
        chk("abort_adc",   32'(ADC_data), 32'h0);
        chk("abort_idle",  32'(spi_bus.CS), 32'd1);
        pulse_start(3'b010, "post_cs_lat");
        wait_dv(400, "post_timeout");
        chk("post_adc", 32'(ADC_data), 32'h150);

        // Back-to-back with start held high.
        step(10);
        dv_base = dv_total;
        channel = 3'b010;
        start   = 1'b1;
        wait_dv(400, "b2b_timeout1");
        dv_first   = dv_cyc;
        data_first = ADC_data;
        wait_dv(400, "b2b_timeout2");
        start = 1'b0;
        chk("b2b_adc1", 32'(data_first), 32'h150);
        chk("b2b_adc2", 32'(ADC_data),   32'h150);
        chk("b2b_gap",  32'(dv_cyc - dv_first), 32'd289);
        step(400);
        chk("b2b_dv_cnt", 32'(dv_total - dv_base), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
